sevenseg_scan_rx: RTL and testbench

Receiver for the multiplexed seven-segment scan interface. It samples the anode-select and segment lines driven by the display multiplexer and debounces each stable (anode, segment) pair. It decodes the segment pattern back to a hex nibble and stores it per digit position, and flags each complete 4-digit frame. It sits on the FPGA loopback self-test path and as an on-board monitor, observing the same pins the scan driver (2-bit select counter plus segment encoder) produces.

---
 rtl/sevenseg_scan_rx.sv | 134 +++++++++++++
 tb/tb_sevenseg_scan_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_rx.sv
// Seven-segment scan receiver: debounces sampled (anode, segment) pairs,
// decodes segment patterns back to hex nibbles per digit and flags complete frames.
module sevenseg_scan_rx #(
    parameter int SETTLE     = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_an,
    input  logic [6:0]  i_seg,
    output logic [15:0] o_digits,
    output logic [3:0]  o_digit_valid,
    output logic        o_frame_valid,
    output logic        o_err
);

    logic [3:0]  w_an;
    logic [6:0]  w_seg;
    logic [3:0]  r_s_an;
    logic [6:0]  r_s_seg;
    logic [7:0]  r_cnt;
    logic [3:0]  r_seen;
    logic [15:0] r_digits;
    logic [3:0]  r_valid;
    logic        r_frame;
    logic        r_err;

    logic        w_same;
    logic        w_capture;
    logic        w_onehot;
    logic        w_multi;
    logic        w_dec_ok;
    logic [3:0]  w_dec_val;
    logic [3:0]  w_seen_or;
    logic [15:0] w_digits_nxt;
    logic [3:0]  w_valid_nxt;
    logic [3:0]  w_seen_nxt;
    logic        w_frame_nxt;
    logic        w_err_nxt;

    assign w_an  = ACTIVE_LOW ? ~i_an  : i_an;
    assign w_seg = ACTIVE_LOW ? ~i_seg : i_seg;

    assign w_same    = (w_an == r_s_an) && (w_seg == r_s_seg);
    // Fires only on the SETTLE-1 -> SETTLE step, so a long stable period captures once.
    assign w_capture = w_same && (r_cnt == 8'(SETTLE - 1));
    assign w_onehot  = (w_an != 4'd0) && ((w_an & (w_an - 4'd1)) == 4'd0);
    assign w_multi   = (w_an != 4'd0) && !w_onehot;
    assign w_seen_or = r_seen | w_an;

    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_val = 4'h0;
        case (w_seg)
            7'h3F: w_dec_val = 4'h0;
            7'h06: w_dec_val = 4'h1;
            7'h5B: w_dec_val = 4'h2;
            7'h4F: w_dec_val = 4'h3;
            7'h66: w_dec_val = 4'h4;
            7'h6D: w_dec_val = 4'h5;
            7'h7D: w_dec_val = 4'h6;
            7'h07: w_dec_val = 4'h7;
            7'h7F: w_dec_val = 4'h8;
            7'h6F: w_dec_val = 4'h9;
            7'h77: w_dec_val = 4'hA;
            7'h7C: w_dec_val = 4'hB;
            7'h39: w_dec_val = 4'hC;
            7'h5E: w_dec_val = 4'hD;
            7'h79: w_dec_val = 4'hE;
            7'h71: w_dec_val = 4'hF;
            default: w_dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_digits_nxt = r_digits;
        w_valid_nxt  = r_valid;
        w_seen_nxt   = r_seen;
        w_frame_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        if (w_capture) begin
            if (w_multi) begin
                w_err_nxt = 1'b1;
            end else if (w_onehot) begin
                if (w_dec_ok) begin
                    for (int k = 0; k < 4; k++) begin
                        if (w_an[k]) w_digits_nxt[4*k +: 4] = w_dec_val;
                    end
                    w_valid_nxt = r_valid | w_an;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_valid_nxt = r_valid & ~w_an;
                end
                if (w_seen_or == 4'hF) begin
                    w_frame_nxt = 1'b1;
                    w_seen_nxt  = 4'h0;
                end else begin
                    w_seen_nxt  = w_seen_or;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_an   <= 4'd0;
            r_s_seg  <= 7'd0;
            r_cnt    <= 8'd0;
            r_seen   <= 4'd0;
            r_digits <= 16'd0;
            r_valid  <= 4'd0;
            r_frame  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_s_an  <= w_an;
            r_s_seg <= w_seg;
            if (!w_same)
                r_cnt <= 8'd0;
            else if (r_cnt != 8'(SETTLE))
                r_cnt <= r_cnt + 8'd1;
            r_seen   <= w_seen_nxt;
            r_digits <= w_digits_nxt;
            r_valid  <= w_valid_nxt;
            r_frame  <= w_frame_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign o_digits      = r_digits;
    assign o_digit_valid = r_valid;
    assign o_frame_valid = r_frame;
    assign o_err         = r_err;

endmodule

// File: tb/tb_sevenseg_scan_rx.sv
// Bench for sevenseg_scan_rx: directed scenarios plus random holds, checked every
// cycle against a run-length/table-lookup reference model.
module tb_sevenseg_scan_rx;

    localparam int SETTLE = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [3:0]  i_an  = 4'hF;
    logic [6:0]  i_seg = 7'h7F;
    logic [15:0] o_digits;
    logic [3:0]  o_digit_valid;
    logic        o_frame_valid;
    logic        o_err;

    sevenseg_scan_rx #(.SETTLE(SETTLE), .ACTIVE_LOW(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_an(i_an), .i_seg(i_seg),
        .o_digits(o_digits), .o_digit_valid(o_digit_valid),
        .o_frame_valid(o_frame_valid), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;
    int frame_seen = 0;
    int err_seen   = 0;

    // reference model state
    logic [3:0]  m_dig [4];
    logic [3:0]  m_valid;
    logic [3:0]  m_seen;
    logic        m_frame;
    logic        m_err;
    logic [10:0] m_prev;
    int          m_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] an, input logic [6:0] seg);
        int k;
        bit found;
        logic [3:0] val;
        m_frame = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_valid = 4'h0;
            m_seen  = 4'h0;
            m_prev  = 11'h0;
            m_run   = 0;
            return;
        end
        if ({an, seg} == m_prev) m_run++;
        else m_run = 1;
        m_prev = {an, seg};
        if (m_run != SETTLE + 1) return;
        if ($countones(an) > 1) begin
            m_err = 1'b1;
        end else if ($countones(an) == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (an[i]) k = i;
            found = 1'b0;
            val = 4'h0;
            for (int v = 0; v < 16; v++) if (seg_tbl[v] == seg) begin found = 1'b1; val = 4'(v); end
            if (found) begin
                m_dig[k] = val;
                m_valid[k] = 1'b1;
            end else begin
                m_err = 1'b1;
                m_valid[k] = 1'b0;
            end
            m_seen[k] = 1'b1;
            if (m_seen == 4'hF) begin
                m_frame = 1'b1;
                m_seen = 4'h0;
            end
        end
    endtask

    // One clock: drive raw (active-low) pins, advance model, compare 1 time unit after the edge.
    task automatic step(input logic rst, input logic [3:0] an_raw, input logic [6:0] seg_raw);
        i_rst = rst;
        i_an  = an_raw;
        i_seg = seg_raw;
        @(posedge i_clk);
        model_edge(rst, ~an_raw, ~seg_raw);
        #1;
        check_eq("digits", 32'(o_digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        check_eq("digit_valid", 32'(o_digit_valid), 32'(m_valid));
        check_eq("frame_valid", 32'(o_frame_valid), 32'(m_frame));
        check_eq("err", 32'(o_err), 32'(m_err));
        if (o_frame_valid) frame_seen++;
        if (o_err) err_seen++;
    endtask

    task automatic hold(input int n, input logic [3:0] an_raw, input logic [6:0] seg_raw);
        for (int i = 0; i < n; i++) step(1'b0, an_raw, seg_raw);
    endtask

    initial begin
        int kind;
        int len;
        logic [3:0] an_n;
        logic [6:0] seg_n;

        // reset with arbitrary pins
        for (int i = 0; i < 2; i++) step(1'b1, 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)));
        check_eq("reset_digits", 32'(o_digits), 32'h0);
        check_eq("reset_valid", 32'(o_digit_valid), 32'h0);
        check_eq("reset_pulses", 32'({o_frame_valid, o_err}), 32'h0);

        // normal scan
        frame_seen = 0; err_seen = 0;
        hold(6, 4'b1110, ~7'h06);
        hold(6, 4'b1101, ~7'h5B);
        hold(6, 4'b1011, ~7'h4F);
        hold(4, 4'b0111, ~7'h66);
        check_eq("scan_no_early_frame", 32'(frame_seen), 32'd0);
        hold(1, 4'b0111, ~7'h66);
        check_eq("scan_frame_5th_edge", 32'(o_frame_valid), 32'd1);
        hold(1, 4'b0111, ~7'h66);
        check_eq("scan_digits", 32'(o_digits), 32'h4321);
        check_eq("scan_valid", 32'(o_digit_valid), 32'hF);
        check_eq("scan_frame_count", 32'(frame_seen), 32'd1);
        check_eq("scan_err_count", 32'(err_seen), 32'd0);

        // glitch rejection
        frame_seen = 0; err_seen = 0;
        hold(4, 4'b1110, ~7'h7F);
        hold(6, 4'b1111, ~7'h00);
        check_eq("glitch_nibble0", 32'(o_digits[3:0]), 32'h1);
        check_eq("glitch_pulses", 32'(frame_seen + err_seen), 32'd0);

        // multi-hot anode held long
        hold(12, 4'b1100, ~7'h3F);
        check_eq("multi_err_count", 32'(err_seen), 32'd1);
        check_eq("multi_digits", 32'(o_digits), 32'h4321);

        // invalid segment
        err_seen = 0;
        hold(6, 4'b1011, ~7'h01);
        check_eq("inval_err_count", 32'(err_seen), 32'd1);
        check_eq("inval_valid2", 32'(o_digit_valid[2]), 32'd0);
        check_eq("inval_nibble2", 32'(o_digits[11:8]), 32'h3);

        // reset mid-frame
        step(1'b1, 4'hF, 7'h7F);
        frame_seen = 0;
        hold(6, 4'b1110, ~7'h6D);
        hold(6, 4'b1101, ~7'h7D);
        step(1'b1, 4'b1101, ~7'h7D);
        check_eq("midrst_digits", 32'(o_digits), 32'h0);
        hold(6, 4'b1011, ~7'h07);
        hold(6, 4'b0111, ~7'h7F);
        hold(6, 4'b1110, ~7'h6F);
        check_eq("midrst_no_frame", 32'(frame_seen), 32'd0);
        hold(6, 4'b1101, ~7'h77);
        check_eq("midrst_frame", 32'(frame_seen), 32'd1);
        check_eq("midrst_digits2", 32'(o_digits), 32'h87A9);

        // random holds
        for (int t = 0; t < 400; t++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 8);
            an_n  = 4'b0001 << $urandom_range(0, 3);
            seg_n = seg_tbl[$urandom_range(0, 15)];
            if (kind == 6) an_n = 4'h0;
            if (kind == 7) an_n = 4'($urandom_range(0, 15)) | 4'b0011;
            if (kind == 8) seg_n = 7'($urandom_range(0, 127));
            if (kind == 9) step(1'b1, ~an_n, ~seg_n);
            else hold(len, ~an_n, ~seg_n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
